uart_fifo_core: RTL and testbench

Parametrised full-duplex UART engine with a configurable baud divider, data width and receive FIFO. It replaces the hard-wired 8N1 transmitter/receiver pair in the pet-status console path. Both directions use valid/ready streaming handshakes, so the status formatter pushes characters into the transmit side and the command decoder pops bytes from the receive side. Receive errors (framing, overrun and, optionally, parity) are reported as single-cycle pulses.

---
 rtl/uart_fifo_core_if.sv | 32 +++
 rtl/uart_fifo_core.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_core_if.sv
// Streaming handshake bundle for uart_fifo_core: transmit valid/ready in,
// receive FIFO valid/ready out, plus receive occupancy and error pulses.
// The core connects through the slave modport; its user connects through master.
interface uart_fifo_core_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [COUNT_W-1:0]   rx_count;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_count,
        input  rx_frame_err, rx_parity_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_count,
        output rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_fifo_core.sv
// Full-duplex UART engine: valid/ready transmitter, oversampling-free
// mid-bit receiver and a first-word-fall-through receive FIFO.
// Optional feature macro: UART_PARITY_EN adds a parity bit to both directions
// (sense chosen by PARITY_ODD); without it frames are start/data/stop only and
// rx_parity_err is constant 0.
module uart_fifo_core #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic             uart_tx,
    uart_fifo_core_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t               tx_state, tx_state_n;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0]     tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_line_n;

    assign bus.tx_ready = (tx_state == S_IDLE);

    // TX next state; the line level is registered from the next state so uart_tx is glitch-free
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_line_n  = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (bus.tx_valid) begin
                    tx_state_n = S_START;
                    tx_cnt_n   = '0;
                    tx_shift_n = bus.tx_data;
                    tx_par_n   = (^bus.tx_data) ^ ODD;
                end
            end
            S_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = S_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == DATA_LAST) tx_state_n = PAR_EN ? S_PARITY : S_STOP;
                    else                     tx_bit_n   = tx_bit + 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_PARITY, S_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = (tx_state == S_PARITY) ? S_STOP : S_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        case (tx_state_n)
            S_START:  tx_line_n = 1'b0;
            S_DATA:   tx_line_n = tx_shift_n[0];
            S_PARITY: tx_line_n = tx_par_n;
            default:  tx_line_n = 1'b1;
        endcase
    end

    // TX control state and serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            uart_tx  <= tx_line_n;
        end
    end

    // TX data holding registers (contents are meaningless while idle)
    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_n;
        tx_par   <= tx_par_n;
    end

    // ---------------- receiver ----------------
    state_t               rx_state, rx_state_n;
    logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
    logic [BIT_W-1:0]     rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_par_bit, rx_par_bit_n;
    logic                 rx_wait_high, rx_wait_high_n;
    logic                 rx_meta, rx_sync;
    logic                 push_req, frame_err_n, par_err_n, overrun_n;
    logic                 frame_err_q, par_err_q, overrun_q;
    logic                 par_bad;

    assign par_bad = ((^rx_shift) ^ ODD) != rx_par_bit;

    // RX next state: mid-bit sampling; after a bad stop bit, wait for idle-high before re-arming
    always_comb begin
        rx_state_n     = rx_state;
        rx_cnt_n       = rx_cnt;
        rx_bit_n       = rx_bit;
        rx_shift_n     = rx_shift;
        rx_par_bit_n   = rx_par_bit;
        rx_wait_high_n = rx_wait_high;
        push_req       = 1'b0;
        frame_err_n    = 1'b0;
        par_err_n      = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_sync) begin
                    rx_wait_high_n = 1'b0;
                end else if (!rx_wait_high) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = '0;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == DATA_LAST) rx_state_n = PAR_EN ? S_PARITY : S_STOP;
                    else                     rx_bit_n   = rx_bit + 1'b1;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n     = '0;
                    rx_par_bit_n = rx_sync;
                    rx_state_n   = S_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_IDLE;
                    if (!rx_sync) begin
                        frame_err_n    = 1'b1;
                        rx_wait_high_n = 1'b1;
                    end else if (PAR_EN && par_bad) begin
                        par_err_n = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // RX synchroniser, control state and registered error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_wait_high <= 1'b0;
            frame_err_q  <= 1'b0;
            par_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta      <= uart_rx;
            rx_sync      <= rx_meta;
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_wait_high <= rx_wait_high_n;
            frame_err_q  <= frame_err_n;
            par_err_q    <= par_err_n;
            overrun_q    <= overrun_n;
        end
    end

    // RX data shift register and received parity bit
    always_ff @(posedge clk) begin
        rx_shift   <= rx_shift_n;
        rx_par_bit <= rx_par_bit_n;
    end

    assign bus.rx_frame_err  = frame_err_q;
    assign bus.rx_parity_err = PAR_EN & par_err_q;
    assign bus.rx_overrun    = overrun_q;

    // ---------------- receive FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic                 full, pop, push;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = bus.rx_valid && bus.rx_ready;
    assign push     = push_req && (!full || pop);
    assign overrun_n = push_req && full && !pop;
    assign wr_ptr_n = push ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_n = pop  ? rd_ptr + 1'b1 : rd_ptr;

    assign bus.rx_valid = (wr_ptr != rd_ptr);
    assign bus.rx_count = wr_ptr - rd_ptr;

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    // Registered head: bypass the incoming byte when it becomes the new head, hold when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rx_data <= '0;
        end else if (wr_ptr_n != rd_ptr_n) begin
            bus.rx_data <= (push && (rd_ptr_n == wr_ptr)) ? rx_shift : mem[rd_ptr_n[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4).
// Stimulus pushes expected received bytes into exp_q; an independent monitor
// pops and compares whenever the FIFO head is consumed, and tallies error pulses.
module tb_uart_fifo_core;
    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 2 + DB + PB;
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic uart_rx;
    logic line = 1'b1;
    logic use_loop = 1'b0;

    assign uart_rx = use_loop ? uart_tx : line;

    uart_fifo_core_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

    uart_fifo_core #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int frame_errs = 0;
    int par_errs = 0;
    int overruns = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // monitor: compare every popped head against the scoreboard and count error pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_frame_err)  frame_errs++;
            if (bus.rx_parity_err) par_errs++;
            if (bus.rx_overrun)    overruns++;
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none t=%0t", bus.rx_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", {24'h0, bus.rx_data}, {24'h0, mon_exp});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // offer one byte to the transmitter and record it as an expected loopback byte
    task automatic tx_send(input logic [7:0] b);
        int guard = 0;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && guard < 500) begin
            tick(1);
            guard++;
        end
        if (!bus.tx_ready) begin
            checks++;
            failures++;
            $display("FAIL tx_accept_timeout actual=busy required=ready");
            bus.tx_valid = 1'b0;
        end else begin
            tick(1);
            bus.tx_valid = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    // send a byte and check the serial waveform and tx_ready cycle by cycle
    task automatic tx_frame_check(input logic [7:0] b);
        logic fb [NBITS];
        fb[0] = 1'b0;
        for (int k = 0; k < DB; k++) fb[1 + k] = b[k];
        if (PB != 0) fb[1 + DB] = ^b;
        fb[NBITS - 1] = 1'b1;
        tx_send(b);
        for (int i = 0; i < FRAME; i++) begin
            check("tx_line", {31'h0, uart_tx}, {31'h0, fb[i / CPB]});
            check("tx_ready_busy", {31'h0, bus.tx_ready}, 32'h0);
            tick(1);
        end
        check("tx_ready_after", {31'h0, bus.tx_ready}, 32'h1);
        check("tx_idle_after", {31'h0, uart_tx}, 32'h1);
    endtask

    // drive a frame directly onto uart_rx with chosen parity and stop bits
    task automatic send_serial(input logic [7:0] b, input logic par, input logic stop);
        line = 1'b0;
        tick(CPB);
        for (int k = 0; k < DB; k++) begin
            line = b[k];
            tick(CPB);
        end
        if (PB != 0) begin
            line = par;
            tick(CPB);
        end
        line = stop;
        tick(CPB);
        line = 1'b1;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            tick(1);
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rx_drain_timeout actual=%0d required=0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int fe0;
        int ov0;
        int model_ov;
        logic [7:0] b;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        // reset state
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_tx_ready", {31'h0, bus.tx_ready}, 32'h1);
        check("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("rst_rx_data", {24'h0, bus.rx_data}, 32'h0);
        check("rst_rx_count", {29'h0, bus.rx_count}, 32'h0);
        check("rst_errs", {29'h0, bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun}, 32'h0);
        rst = 1'b0;
        tick(1);
        check("post_rst_uart_tx", {31'h0, uart_tx}, 32'h1);

        // 0x41 waveform, looped back into the receiver
        use_loop = 1'b1;
        tx_frame_check(8'h41);
        wait_drain();

        // back-to-back loopback: fixed corner bytes then random bytes
        tx_send(8'h00);
        tx_send(8'hFF);
        tx_send(8'hA5);
        for (int i = 0; i < 8; i++) tx_send(8'($urandom_range(0, 255)));
        wait_drain();
        check("loop_frame_errs", frame_errs, 0);
        check("loop_overruns", overruns, 0);
        check("loop_par_errs", par_errs, 0);

        // one-cycle low glitch is a false start
        use_loop = 1'b0;
        tick(4);
        line = 1'b0;
        tick(1);
        line = 1'b1;
        tick(3 * CPB);
        check("glitch_rx_count", {29'h0, bus.rx_count}, 32'h0);
        check("glitch_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("glitch_frame_errs", frame_errs, 0);

        // stop bit forced low
        fe0 = frame_errs;
        send_serial(8'h5A, ^8'h5A, 1'b0);
        tick(3 * CPB);
        check("stop_low_frame_err", frame_errs, fe0 + 1);
        check("stop_low_rx_count", {29'h0, bus.rx_count}, 32'h0);

`ifdef UART_PARITY_EN
        // even parity: 0x03 needs parity bit 0
        send_serial(8'h03, 1'b1, 1'b1);
        tick(3 * CPB);
        check("parity_bad_err", par_errs, 1);
        check("parity_bad_count", {29'h0, bus.rx_count}, 32'h0);
        exp_q.push_back(8'h03);
        send_serial(8'h03, 1'b0, 1'b1);
        wait_drain();
        check("parity_good_err", par_errs, 1);
`endif

        // overrun: consumer stalled, DEPTH+1 frames
        bus.rx_ready = 1'b0;
        ov0 = overruns;
        model_ov = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else model_ov++;
            send_serial(b, ^b, 1'b1);
        end
        tick(3 * CPB);
        check("ovr_rx_count", {29'h0, bus.rx_count}, DEPTH);
        check("ovr_pulses", overruns, ov0 + model_ov);
        check("ovr_rx_valid", {31'h0, bus.rx_valid}, 32'h1);
        bus.rx_ready = 1'b1;
        wait_drain();
        tick(2);
        check("ovr_drained_count", {29'h0, bus.rx_count}, 32'h0);

        // reset in the middle of a transmit frame
        use_loop = 1'b1;
        tick(2);
        tx_send(8'($urandom_range(0, 255)));
        void'(exp_q.pop_back());
        tick(15);
        rst = 1'b1;
        tick(1);
        check("midrst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("midrst_tx_ready", {31'h0, bus.tx_ready}, 32'h1);
        check("midrst_rx_count", {29'h0, bus.rx_count}, 32'h0);
        rst = 1'b0;
        tick(2);
        tx_frame_check(8'h3C);
        for (int i = 0; i < 6; i++) tx_send(8'($urandom_range(0, 255)));
        wait_drain();
        tick(4);
        check("final_frame_errs", frame_errs, fe0 + 1);
        check("final_overruns", overruns, ov0 + 1);
        check("final_par_errs", par_errs, PB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
